// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizes for the 64x15 fakeram request controller.
package sram_ctrl_pkg;

  localparam int BITS_DEF       = 15;
  localparam int ADDR_WIDTH_DEF = 6;
  localparam int WORD_DEPTH_DEF = 64;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/sram_resp_fifo.sv
// Small in-order response FIFO; count is exported so the controller can
// reserve a slot for every read before it reaches the macro.
module sram_resp_fifo #(
  parameter int BITS  = 15,
  parameter int DEPTH = 3,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_v,
  input  logic [BITS-1:0] push_data,
  output logic            push_ready,
  output logic            pop_v,
  input  logic            pop_ready,
  output logic [BITS-1:0] pop_data,
  output logic [CW-1:0]   count
);

  logic [BITS-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push_ready = (count != CW'(DEPTH));
  assign pop_v      = (count != '0);
  assign pop_data   = mem[rd_ptr];
  assign do_push    = push_v & push_ready;
  assign do_pop     = pop_v & pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  // The upstream credit check makes this unreachable; a hit means lost data.
  assert property (@(posedge clk) disable iff (!rst_n) !(push_v && !push_ready))
    else $error("response fifo push while full");

endmodule

// File: rtl/sram_64x15_req_ctrl.sv
// Sole driver of the 64x15 fakeram pins: zero-fills after reset, then
// forwards valid/ready requests and queues read data with credit backpressure.
//
// state    | meaning
// ST_START | one idle cycle after reset release
// ST_INIT  | writing zero to addr init_cnt, one word per cycle
// ST_RUN   | forwarding requests; terminal until reset
module sram_64x15_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int BITS       = BITS_DEF,
  parameter int WORD_DEPTH = WORD_DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int RESP_DEPTH = 3,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_v_in,
  output logic                  req_ready_out,
  input  logic                  req_we_in,
  input  logic [ADDR_WIDTH-1:0] req_addr_in,
  input  logic [BITS-1:0]       req_data_in,
  input  logic [BITS-1:0]       req_mask_in,
  output logic                  resp_v_out,
  input  logic                  resp_ready_in,
  output logic [BITS-1:0]       resp_data_out,
  output logic                  init_done_out,
  output logic                  sram_ce_out,
  output logic                  sram_we_out,
  output logic [ADDR_WIDTH-1:0] sram_addr_out,
  output logic [BITS-1:0]       sram_wd_out,
  output logic [BITS-1:0]       sram_w_mask_out,
  input  logic [BITS-1:0]       sram_rd_in
);

  localparam int CW = $clog2(RESP_DEPTH + 1);

  ctrl_state_e           state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  inflight;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_push_ready;
  logic [CW:0]           credit_used;
  logic                  req_fire;

  // A read holds a slot from acceptance until its response is popped.
  assign credit_used   = {1'b0, fifo_count} + (CW + 1)'(inflight);
  assign req_ready_out = (state == ST_RUN) &
                         (req_we_in | (credit_used < (CW + 1)'(RESP_DEPTH)));
  assign req_fire      = req_v_in & req_ready_out;

  always_comb begin
    sram_ce_out     = 1'b0;
    sram_we_out     = 1'b0;
    sram_addr_out   = '0;
    sram_wd_out     = '0;
    sram_w_mask_out = '0;
    case (state)
      ST_INIT: begin
        sram_ce_out     = 1'b1;
        sram_we_out     = 1'b1;
        sram_addr_out   = init_cnt;
        sram_w_mask_out = '1;
      end
      ST_RUN: begin
        if (req_fire) begin
          sram_ce_out     = 1'b1;
          sram_we_out     = req_we_in;
          sram_addr_out   = req_addr_in;
          sram_wd_out     = req_data_in;
          sram_w_mask_out = req_mask_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_START;
      init_cnt      <= '0;
      inflight      <= 1'b0;
      init_done_out <= 1'b0;
    end else begin
      inflight <= req_fire & ~req_we_in;
      case (state)
        ST_START: begin
          if (INIT_EN) begin
            state <= ST_INIT;
          end else begin
            state         <= ST_RUN;
            init_done_out <= 1'b1;
          end
        end
        ST_INIT: begin
          init_cnt <= init_cnt + ADDR_WIDTH'(1);
          if (init_cnt == ADDR_WIDTH'(WORD_DEPTH - 1)) begin
            state         <= ST_RUN;
            init_done_out <= 1'b1;
          end
        end
        ST_RUN: ;
        default: state <= ST_START;
      endcase
    end
  end

  sram_resp_fifo #(
    .BITS  (BITS),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_v     (inflight),
    .push_data  (sram_rd_in),
    .push_ready (fifo_push_ready),
    .pop_v      (resp_v_out),
    .pop_ready  (resp_ready_in),
    .pop_data   (resp_data_out),
    .count      (fifo_count)
  );

  // The macro corrupts its array if addr/we are unknown while enabled.
  assert property (@(posedge clk) disable iff (!rst_n)
    sram_ce_out |-> !$isunknown({sram_we_out, sram_addr_out}))
    else $error("unknown macro addr/we while ce high");

  assert property (@(posedge clk) disable iff (!rst_n) inflight |-> fifo_push_ready)
    else $error("read returned with no fifo slot reserved");

endmodule

// File: doc/sram_64x15_req_ctrl.md
Name: sram_64x15_req_ctrl

Overview:
Request-side controller placed directly upstream of the 64x15 single-port fakeram macro; the only block that drives its pins.
- Accepts read/write requests on a valid/ready interface.
- Clears the whole array to zero after reset.
- Tracks the macro's 1-cycle read latency and captures read data into a response FIFO with backpressure.
- Never presents X on macro address or write-enable while chip-enable is high, so the macro's X-corruption path is never triggered.

Parameters:
BITS, 15, data and mask width
WORD_DEPTH, 64, number of macro words
ADDR_WIDTH, 6, address width; must satisfy 2**ADDR_WIDTH == WORD_DEPTH
RESP_DEPTH, 3, response FIFO entries; must be >= 3 to sustain 1 read/cycle
INIT_EN, 1, 1 = zero-fill the array after reset; 0 = skip zero-fill

Ports:
clk  input  1  clock; rising edge
rst_n  input  1  asynchronous active-low reset
req_v_in  input  1  request valid
req_ready_out  output  1  request accepted when req_v_in & req_ready_out
req_we_in  input  1  1 = write, 0 = read
req_addr_in  input  ADDR_WIDTH  word address
req_data_in  input  BITS  write data
req_mask_in  input  BITS  per-bit write mask; 1 = write this bit
resp_v_out  output  1  read response valid
resp_ready_in  input  1  response consumed when resp_v_out & resp_ready_in
resp_data_out  output  BITS  read data, FIFO head
init_done_out  output  1  high once state is RUN
sram_ce_out  output  1  to macro ce_in
sram_we_out  output  1  to macro we_in
sram_addr_out  output  ADDR_WIDTH  to macro addr_in
sram_wd_out  output  BITS  to macro wd_in
sram_w_mask_out  output  BITS  to macro w_mask_in
sram_rd_in  input  BITS  from macro rd_out

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = START, init counter = 0, inflight = 0, FIFO empty.
  - All outputs 0: req_ready_out, resp_v_out, init_done_out, sram_ce_out, sram_we_out, sram_addr_out, sram_wd_out, sram_w_mask_out. resp_data_out = 0.
- FSM:
  - START: 1 cycle, then INIT if INIT_EN=1, else RUN.
  - INIT: each cycle ce=1, we=1, addr=counter, wd=0, mask=all-ones; counter increments. After addr WORD_DEPTH-1 is issued, go to RUN (64 cycles total at defaults).
  - RUN: terminal until the next reset.
- req_ready_out = (state==RUN) & (req_we_in | (fifo_count + inflight < RESP_DEPTH)).
  - Depends only on registered state and req_we_in; no combinational path from resp_ready_in.
  - Writes never wait on FIFO space.
- Macro drive in RUN is combinational:
  - sram_ce_out = req_v_in & req_ready_out.
  - When ce=1: we, addr, wd, mask pass through from the request.
  - When ce=0: we, addr, wd, mask are forced to 0.
- Writes produce no response. Write latency is one edge; a read of the same address in the next cycle returns the new data.
- Read issued in cycle t:
  - inflight register = 1 in cycle t+1; sram_rd_in is sampled at the end of t+1 and pushed into the FIFO.
  - Earliest resp_v_out is cycle t+2.
  - Read-to-response latency is 2 cycles when the FIFO is empty.
- sram_rd_in is sampled only when inflight=1; it is don't-care otherwise, because the macro outputs X when ce is low.
- FIFO:
  - Responses are in order; resp_data_out is the head and holds stable while resp_v_out & !resp_ready_in.
  - Push and pop in the same cycle: count unchanged, pointers both advance.
  - Pointers wrap modulo RESP_DEPTH.
  - Overflow is impossible by the credit rule; assertion: push while full is an error.
- Throughput: 1 request/cycle sustained, for any read/write mix, while the consumer keeps resp_ready_in high.
- Reset mid-INIT or mid-RUN: inflight read and FIFO contents are discarded, zero-fill restarts from addr 0, and no spurious response appears after reset.
- init_done_out is registered: it goes high in the first RUN cycle and stays high until reset.

Decomposition:
- Package sram_ctrl_pkg holds:
  - state enum {START, INIT, RUN}, 2 bits;
  - default width constants: BITS=15, ADDR_WIDTH=6, WORD_DEPTH=64.
- Sub-module sram_resp_fifo: parameterised BITS x RESP_DEPTH, valid/ready on both sides, async active-low reset, exposes count for the credit check.
- The controller keeps the FSM, init counter, inflight flag and macro drive muxing.

Test Plan:
- Reset release with INIT_EN=1 -> exactly 64 cycles of ce=1, we=1, mask=0x7FFF, wd=0, addr 0..63 in order; init_done_out rises next cycle; a read of addr 17 then returns 0x0000.
- Write addr 5 data 0x1234 mask 0x7FFF, then read addr 5 in the next cycle -> resp_v_out 2 cycles after the read, data 0x1234.
- Masked write: addr 9 holds 0x7FFF, write data 0x0000 mask 0x00FF -> a read of addr 9 returns 0x7F00.
- Backpressure: resp_ready_in=0, 5 back-to-back reads -> exactly 3 accepted, req_ready_out low while count+inflight=3, writes still accepted. Raise resp_ready_in -> responses drain in issue order and the remaining reads are accepted.
- Streaming: reads of addr 0..63 on consecutive cycles with resp_ready_in=1 -> 64 responses on consecutive cycles with no bubble; FIFO count stays at 1 with simultaneous push/pop.
- Reset asserted at INIT counter 30, and again with 2 responses queued -> all outputs 0 immediately; after release INIT restarts at addr 0 and no stale resp_v_out appears; sram_addr_out/sram_we_out are never X while sram_ce_out=1 (assertion).
